// File: rtl/mac_row_ctrl.sv
// Load+execute sequencer for one MAC row: streams col weights, then num_act
// activations, then waits for the last column to return num_act results.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; mode/count latched on accept
// LOAD  | accepting col weights, issuing kernel-load instructions
// EXEC  | accepting num_act activations, issuing execute instructions
// DRAIN | waiting for the last column to report num_act valid outputs
// DONE  | one-cycle completion pulse, start ignored
module mac_row_ctrl #(
  parameter int bw     = 4,
  parameter int col    = 8,
  parameter int cnt_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_2b_in,
  input  logic [cnt_bw-1:0] num_act,
  input  logic [bw-1:0]     w_data,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [bw-1:0]     x_data,
  input  logic              x_valid,
  output logic              x_ready,
  output logic [bw-1:0]     in_w,
  output logic [1:0]        inst_w,
  output logic              mode_2b,
  input  logic [col-1:0]    row_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EXEC,
    DRAIN,
    DONE
  } state_t;

  localparam logic [cnt_bw-1:0] last_w = cnt_bw'(col - 1);
  localparam logic [cnt_bw-1:0] one    = cnt_bw'(1);

  state_t            state, state_nxt;
  logic [cnt_bw-1:0] w_cnt, x_cnt, o_cnt, num_act_q;
  logic [cnt_bw-1:0] o_cnt_nxt;
  logic              w_xfer, x_xfer, o_inc, accept;

  assign w_ready = (state == LOAD);
  assign x_ready = (state == EXEC);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  assign w_xfer  = w_ready && w_valid;
  assign x_xfer  = x_ready && x_valid;
  assign accept  = (state == IDLE) && start;

  // Saturating so a stray extra result pulse can never wrap the count.
  assign o_inc     = row_valid[col-1] && ((state == EXEC) || (state == DRAIN)) && (o_cnt != '1);
  assign o_cnt_nxt = o_cnt + cnt_bw'(o_inc);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (w_xfer && (w_cnt == last_w))
                 state_nxt = (num_act_q != '0) ? EXEC : DONE;
      EXEC:    if (x_xfer && (x_cnt == num_act_q - one)) state_nxt = DRAIN;
      DRAIN:   if (o_cnt_nxt == num_act_q) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      w_cnt     <= '0;
      x_cnt     <= '0;
      o_cnt     <= '0;
      num_act_q <= '0;
      mode_2b   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        w_cnt     <= '0;
        x_cnt     <= '0;
        o_cnt     <= '0;
        num_act_q <= num_act;
        mode_2b   <= mode_2b_in;
      end else begin
        if (w_xfer) w_cnt <= w_cnt + one;
        if (x_xfer) x_cnt <= x_cnt + one;
        o_cnt <= o_cnt_nxt;
      end
    end
  end

  // Row-side instruction register; any non-transfer cycle becomes a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_w   <= '0;
      inst_w <= 2'b00;
    end else if (w_xfer) begin
      in_w   <= w_data;
      inst_w <= 2'b01;
    end else if (x_xfer) begin
      in_w   <= x_data;
      inst_w <= 2'b10;
    end else begin
      in_w   <= '0;
      inst_w <= 2'b00;
    end
  end

endmodule
